// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 host-side blocks: FSM state encoding and error codes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        FINISH
    } ps2_state_e;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_NACK     = 2'd1;
    localparam logic [1:0] ERR_START_TO = 2'd2;
    localparam logic [1:0] ERR_XFER_TO  = 2'd3;

endpackage

// File: rtl/ps2_pin_filter.sv
// PS/2 pin conditioner: 2-flop synchroniser, FILTER_CYCLES stability filter and a
// one-cycle pulse on each accepted 1->0 transition. Idle level of the bus is high.
module ps2_pin_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // A new level is accepted on the FILTER_CYCLES-th consecutive differing sample.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync_q[1];
                fall_q  <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain CLK/DAT via output enables.
// Optional build macro PS2_HOST_TX_RETRY_EN: one automatic retry after NACK or timeout.
//
// state     | meaning
// IDLE      | pins released, waiting for start_i
// INHIBIT   | clock held low; last cycle overlaps the start bit on data
// REQ       | clock released, data low, waiting for the device's first clock
// DATA      | data bits, parity and stop driven on each device clock fall
// ACK       | waiting for fall 11 to sample the device acknowledge
// WAIT_IDLE | waiting for both lines to return high
// FINISH    | one-cycle done pulse with error code, then back to IDLE
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 15000,
    parameter int START_TIMEOUT_CYCLES = 1875000,
    parameter int XFER_TIMEOUT_CYCLES  = 250000,
    parameter int FILTER_CYCLES        = 8
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [7:0] tx_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] error_o,
    output logic       rx_inhibit_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o
);

    localparam int PT_MAX = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                   : START_TIMEOUT_CYCLES;
    localparam int TW = $clog2(PT_MAX + 1);
    localparam int XW = $clog2(XFER_TIMEOUT_CYCLES + 1);
    // INHIBIT lasts one cycle less than the clock-low time; the REQ entry cycle covers the rest.
    localparam logic [TW-1:0] INH_LOAD   = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] START_LOAD = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [XW-1:0] XFER_LOAD  = XW'(XFER_TIMEOUT_CYCLES - 1);

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [XW-1:0] xfer_q, xfer_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [8:0]    frame_q, frame_d;
    logic [1:0]    error_q, error_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          fin_q;
    logic          fail;
    logic [1:0]    fail_code;
    logic [3:0]    nxt_idx;
    logic          clk_level, clk_fall, dat_level, dat_fall_unused;
`ifdef PS2_HOST_TX_RETRY_EN
    logic          retry_q, retry_d;
`endif

    ps2_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .pin_i   (ps2_clk_i),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filt (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .pin_i   (ps2_dat_i),
        .level_o (dat_level),
        .fall_o  (dat_fall_unused)
    );

    assign nxt_idx = bitcnt_q + 4'd1;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            xfer_q   <= '0;
            bitcnt_q <= '0;
            frame_q  <= '0;
            error_q  <= ERR_OK;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            fin_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            xfer_q   <= xfer_d;
            bitcnt_q <= bitcnt_d;
            frame_q  <= frame_d;
            error_q  <= error_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            fin_q    <= (state_q == FINISH);
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        xfer_d    = xfer_q;
        bitcnt_d  = bitcnt_q;
        frame_d   = frame_q;
        error_d   = error_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        fail      = 1'b0;
        fail_code = ERR_OK;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            IDLE: if (start_i) begin
                frame_d  = {~^tx_data_i, tx_data_i};
                error_d  = ERR_OK;
                timer_d  = INH_LOAD;
                clk_oe_d = 1'b1;
                dat_oe_d = 1'b0;
                state_d  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                retry_d  = 1'b0;
`endif
            end
            INHIBIT: if (timer_q == '0) begin
                dat_oe_d = 1'b1;
                timer_d  = START_LOAD;
                state_d  = REQ;
            end else begin
                timer_d = timer_q - 1'b1;
            end
            REQ: begin
                clk_oe_d = 1'b0;
                if (clk_fall) begin
                    bitcnt_d = '0;
                    dat_oe_d = ~frame_q[0];
                    xfer_d   = XFER_LOAD;
                    state_d  = DATA;
                end else if (timer_q == '0) begin
                    fail      = 1'b1;
                    fail_code = ERR_START_TO;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA, ACK, WAIT_IDLE: if (xfer_q == '0) begin
                fail      = 1'b1;
                fail_code = ERR_XFER_TO;
            end else begin
                xfer_d = xfer_q - 1'b1;
                if (state_q == DATA && clk_fall) begin
                    bitcnt_d = nxt_idx;
                    if (bitcnt_q == 4'd8) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end else begin
                        dat_oe_d = ~frame_q[nxt_idx];
                    end
                end else if (state_q == ACK && clk_fall) begin
                    error_d = dat_level ? ERR_NACK : ERR_OK;
                    state_d = WAIT_IDLE;
                end else if (state_q == WAIT_IDLE && clk_level && dat_level) begin
                    if (error_q == ERR_NACK) begin
                        fail      = 1'b1;
                        fail_code = ERR_NACK;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            state_d  = FINISH;
            error_d  = fail_code;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retry_q) begin
                retry_d  = 1'b1;
                error_d  = ERR_OK;
                timer_d  = INH_LOAD;
                clk_oe_d = 1'b1;
                state_d  = INHIBIT;
            end
`endif
        end
    end

    assign busy_o       = (state_q != IDLE) && (state_q != FINISH);
    assign done_o       = (state_q == FINISH);
    assign error_o      = error_q;
    assign rx_inhibit_o = busy_o | done_o | fin_q;
    assign ps2_clk_oe_o = clk_oe_q;
    assign ps2_dat_oe_o = dat_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xED set LEDs) to a PS/2 mouse or keyboard.
- This is the reverse direction of the existing device-to-host mouse and keyboard receivers.
- Sits beside those receivers on the same open-drain PS2_CLK/PS2_DAT pins, driving them through output-enables. It is started from a hwregs write strobe.

Parameters:
- INHIBIT_CYCLES, 15000: clock-low inhibit time (120 us at 125 MHz).
- START_TIMEOUT_CYCLES, 1875000: maximum wait for the device's first falling clock edge (15 ms).
- XFER_TIMEOUT_CYCLES, 250000: maximum time from first edge to ack (2 ms).
- FILTER_CYCLES, 8: number of consecutive synchronised samples needed to accept a new pin level.

Ports:
- clock, input, 1: system clock, 125 MHz.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to send tx_data.
- tx_data, input, 8: byte to send; captured when start is accepted.
- busy, output, 1: transfer in progress.
- done, output, 1: one-cycle pulse at the end of a transfer.
- error, output, 2: valid with done. 0 = ok, 1 = NACK, 2 = start timeout, 3 = transfer timeout.
- rx_inhibit, output, 1: tells the sibling receiver to ignore pin activity.
- ps2_clk_in, input, 1: raw PS2_CLK pin level.
- ps2_dat_in, input, 1: raw PS2_DAT pin level.
- ps2_clk_oe, output, 1: 1 drives PS2_CLK low; 0 releases it.
- ps2_dat_oe, output, 1: 1 drives PS2_DAT low; 0 releases it.

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; busy, done, error, rx_inhibit, ps2_clk_oe, ps2_dat_oe all 0; bit counter 0.
  - Reset mid-transfer releases both pins immediately.
- Input conditioning: 2-flop synchroniser, then the FILTER_CYCLES stability filter. A falling edge (fall) is a filtered 1->0 transition.
- Start handshake:
  - start in IDLE: latch tx_data, compute odd parity (~^tx_data), go to INHIBIT. busy is 1 from the next cycle.
  - start while busy is ignored; no queueing.
- INHIBIT: ps2_clk_oe=1, timer counts to INHIBIT_CYCLES-1.
  - On expiry: ps2_dat_oe=1 (start bit); ps2_clk_oe stays 1 for one more cycle, then 0; go to REQ.
- REQ: clock released, data held low, timer counts START_TIMEOUT_CYCLES.
  - fall -> DATA, with bit counter 0 and data output set to bit 0.
  - Timer expiry -> FINISH with error=2.
- DATA: data changes only on fall (the device samples on the rising edge).
  - Falls 1..8 drive bits 0..7 LSB first, via ps2_dat_oe = ~bit.
  - Fall 9 drives parity; fall 10 releases data (stop bit); go to ACK.
- ACK: on fall 11, sample the filtered data. 0 = ack (error=0), 1 = NACK (error=1). Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock=1 and data=1, then FINISH.
- XFER_TIMEOUT_CYCLES runs from the first fall until FINISH is reached. Expiry in DATA, ACK or WAIT_IDLE -> FINISH with error=3.
- FINISH:
  - Release both pins, pulse done for 1 cycle, error stable in that cycle, busy=0 in the same cycle, return to IDLE.
  - start in the FINISH cycle is ignored; it is accepted only from IDLE.
- rx_inhibit = busy, plus one extra cycle after FINISH.
- Glitches shorter than FILTER_CYCLES produce no fall.
- Timers saturate and never wrap.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On NACK or either timeout, the block re-enters INHIBIT once with the same byte and parity; busy stays 1.
  - done/error are reported only after the retry; error reflects the second attempt.
  - A 1-bit retry flag is cleared on start.
- Undefined: there is no retry; the first failure is reported.

Decomposition:
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE, FINISH;
  - the error code localparams: ERR_OK, ERR_NACK, ERR_START_TO, ERR_XFER_TO.
- Sub-module ps2_pin_filter, instantiated twice: synchroniser + stability filter + fall pulse.
- The existing receivers adopt ps2_pin_filter later.

Test Plan:
- tx_data=0xF4, device model clocks at 12.5 kHz and acks:
  - ps2_clk_oe high for exactly 15000 cycles;
  - device captures bits 0,0,1,0,1,1,1,1, parity 0, stop 1;
  - done with error=0 within 1.2 ms.
- tx_data=0xFF and 0x00: captured parity is 1 for both; 0x01 gives parity 0.
- Device never clocks: done with error=2 at 15000+1875000 (±2) cycles; both oe=0 afterwards.
- Device stops after 5 clocks: done with error=3; pins released.
- Device leaves data high on fall 11:
  - done with error=1;
  - with PS2_HOST_TX_RETRY_EN, a second INHIBIT phase follows and a subsequent ack reports error=0.
- Edge cases:
  - start pulsed again mid-transfer is ignored; the captured byte is unchanged.
  - Reset asserted during DATA: both oe drop asynchronously and busy=0.
  - A 4-cycle clock glitch in REQ produces no transition.
